// File: rtl/vc_lru_update_pkg.sv
// Shared types and constants for the victim-cache LRU update engine.
package vc_lru_update_pkg;

  localparam int VC_WAYS  = 8;
  localparam int VC_IDX_W = 3;

  typedef logic [2:0]  vc_way_t;
  typedef logic [23:0] vc_lru_t;

  typedef enum logic [1:0] {
    VC_LRU_IDLE   = 2'd0,
    VC_LRU_SCAN   = 2'd1,
    VC_LRU_COMMIT = 2'd2
  } vc_lru_state_t;

endpackage

// File: rtl/vc_lru_update_shift.sv
// Combinational LRU reorder: the way found at field i_pos is promoted to MRU.
module vc_lru_shift
  import vc_lru_update_pkg::*;
#(
  parameter int WAYS  = VC_WAYS,
  parameter int IDX_W = VC_IDX_W
)(
  input  logic [WAYS*IDX_W-1:0] i_snap,
  input  logic [IDX_W-1:0]      i_pos,
  input  logic [IDX_W-1:0]      i_way,
  output logic [WAYS*IDX_W-1:0] o_word
);

  // Fields below the hit stay put, fields above slide one step toward LRU.
  always_comb begin
    o_word = {(WAYS*IDX_W){1'b0}};
    for (int q = 0; q < WAYS-1; q++) begin
      if (q >= int'(i_pos)) begin
        o_word[q*IDX_W +: IDX_W] = i_snap[(q+1)*IDX_W +: IDX_W];
      end else begin
        o_word[q*IDX_W +: IDX_W] = i_snap[q*IDX_W +: IDX_W];
      end
    end
    o_word[(WAYS-1)*IDX_W +: IDX_W] = i_way;
  end

endmodule

// File: rtl/vc_lru_update.sv
// Victim-cache LRU update engine: promotes a touched way to MRU and writes the word back.
// Build macro VC_LRU_FAST_EN replaces the serial field scan with a single-cycle parallel compare.
module vc_lru_update
  import vc_lru_update_pkg::*;
#(
  parameter  int WAYS  = VC_WAYS,
  parameter  int IDX_W = VC_IDX_W,
  localparam int LRU_W = WAYS*IDX_W
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             touch_valid,
  input  logic [IDX_W-1:0] touch_way,
  output logic             touch_ready,
  output logic             touch_done,
  input  logic [LRU_W-1:0] lru_rdata,
  output logic             lru_write,
  output logic [LRU_W-1:0] lru_wdata,
  output logic [IDX_W-1:0] victim_way,
  output logic             victim_valid,
  output logic             lru_err
);

  localparam logic [IDX_W-1:0] MRU_POS = IDX_W'(WAYS-1);

  vc_lru_state_t    r_state;
  vc_lru_state_t    w_state_nxt;
  logic             r_done;
  logic             r_write;
  logic             r_err;
  logic [LRU_W-1:0] r_wdata;
  logic [LRU_W-1:0] w_shift;
  logic [LRU_W-1:0] w_shift_src;
  logic [IDX_W-1:0] w_hit_p;
  logic [IDX_W-1:0] w_shift_way;
  logic             w_commit;
  logic             w_miss;
  logic             w_do_write;

`ifdef VC_LRU_FAST_EN
  logic w_any_hit;

  // Highest matching field wins, the same field a descending scan would stop at.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_p   = {IDX_W{1'b0}};
    for (int q = 0; q < WAYS; q++) begin
      if (lru_rdata[q*IDX_W +: IDX_W] == touch_way) begin
        w_any_hit = 1'b1;
        w_hit_p   = IDX_W'(q);
      end else begin
        w_any_hit = w_any_hit;
      end
    end
  end

  assign w_shift_src = lru_rdata;
  assign w_shift_way = touch_way;
`else
  logic [LRU_W-1:0] r_snap;
  logic [IDX_W-1:0] r_way;
  logic [IDX_W-1:0] r_ptr;
  logic             w_field_hit;

  assign w_field_hit = (r_snap[r_ptr*IDX_W +: IDX_W] == r_way);
  assign w_hit_p     = r_ptr;
  assign w_shift_src = r_snap;
  assign w_shift_way = r_way;

  // Snapshot the word on accept, then walk the pointer from MRU toward LRU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap <= {LRU_W{1'b0}};
      r_way  <= {IDX_W{1'b0}};
      r_ptr  <= MRU_POS;
    end else if ((r_state == VC_LRU_IDLE) && touch_valid) begin
      r_snap <= lru_rdata;
      r_way  <= touch_way;
      r_ptr  <= MRU_POS;
    end else if (r_state == VC_LRU_SCAN) begin
      r_ptr  <= r_ptr - {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end
`endif

  vc_lru_shift #(.WAYS(WAYS), .IDX_W(IDX_W)) u_shift (
    .i_snap (w_shift_src),
    .i_pos  (w_hit_p),
    .i_way  (w_shift_way),
    .o_word (w_shift)
  );

  // Next state plus the commit/miss decision that feeds the pulse registers.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      VC_LRU_IDLE: begin
        if (touch_valid) begin
`ifdef VC_LRU_FAST_EN
          w_state_nxt = VC_LRU_COMMIT;
          w_commit    = 1'b1;
          w_miss      = ~w_any_hit;
`else
          w_state_nxt = VC_LRU_SCAN;
`endif
        end else begin
          w_state_nxt = VC_LRU_IDLE;
        end
      end
`ifdef VC_LRU_FAST_EN
`else
      VC_LRU_SCAN: begin
        if (w_field_hit) begin
          w_state_nxt = VC_LRU_COMMIT;
          w_commit    = 1'b1;
        end else if (r_ptr == {IDX_W{1'b0}}) begin
          w_state_nxt = VC_LRU_COMMIT;
          w_commit    = 1'b1;
          w_miss      = 1'b1;
        end else begin
          w_state_nxt = VC_LRU_SCAN;
        end
      end
`endif
      VC_LRU_COMMIT: w_state_nxt = VC_LRU_IDLE;
      default:       w_state_nxt = VC_LRU_IDLE;
    endcase
  end

  // A way already in MRU needs no write-back.
  assign w_do_write = w_commit & ~w_miss & (w_hit_p != MRU_POS);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= VC_LRU_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Done and write are single-cycle pulses; write data and the error flag hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= {LRU_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_done  <= w_commit;
      r_write <= w_do_write;
      if (w_do_write) begin
        r_wdata <= w_shift;
      end
      if (w_commit && w_miss) begin
        r_err <= 1'b1;
      end
    end
  end

  assign touch_ready  = (r_state == VC_LRU_IDLE);
  assign victim_valid = (r_state == VC_LRU_IDLE);
  assign victim_way   = lru_rdata[IDX_W-1:0];
  assign touch_done   = r_done;
  assign lru_write    = r_write;
  assign lru_wdata    = r_wdata;
  assign lru_err      = r_err;

endmodule

// File: tb/tb_vc_lru_update.sv
// Self-checking bench for vc_lru_update: directed vectors, corner sequences and a queue-based model.
module tb_vc_lru_update;

  localparam int WAYS  = 8;
  localparam int IDX_W = 3;
  localparam int LRU_W = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             touch_valid;
  logic [IDX_W-1:0] touch_way;
  logic             touch_ready;
  logic             touch_done;
  logic [LRU_W-1:0] lru_rdata;
  logic             lru_write;
  logic [LRU_W-1:0] lru_wdata;
  logic [IDX_W-1:0] victim_way;
  logic             victim_valid;
  logic             lru_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vc_lru_update #(.WAYS(WAYS), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .touch_valid  (touch_valid),
    .touch_way    (touch_way),
    .touch_ready  (touch_ready),
    .touch_done   (touch_done),
    .lru_rdata    (lru_rdata),
    .lru_write    (lru_write),
    .lru_wdata    (lru_wdata),
    .victim_way   (victim_way),
    .victim_valid (victim_valid),
    .lru_err      (lru_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Cycle (counted from the handshake cycle) at which done is expected; p<0 means no match.
  function automatic int lat(input int p);
`ifdef VC_LRU_FAST_EN
    lat = 1;
`else
    lat = (p < 0) ? WAYS + 1 : WAYS - p + 1;
`endif
  endfunction

  // Reference: list fields LRU-first, find the touched way nearest MRU, remove it, append it.
  function automatic void model(input logic [LRU_W-1:0] word, input logic [IDX_W-1:0] way,
                                output int p, output logic [LRU_W-1:0] nw);
    logic [IDX_W-1:0] q[$];
    logic [IDX_W-1:0] f;
    p  = -1;
    nw = word;
    for (int i = 0; i < WAYS; i++) begin
      f = word[i*IDX_W +: IDX_W];
      q.push_back(f);
      if (f == way) p = i;
    end
    if (p >= 0) begin
      q.delete(p);
      q.push_back(way);
      for (int i = 0; i < WAYS; i++) nw[i*IDX_W +: IDX_W] = q[i];
    end
  endfunction

  task automatic run_touch(input string tag, input logic [LRU_W-1:0] word, input logic [IDX_W-1:0] way,
                           input int exp_done, input logic exp_wr, input logic [LRU_W-1:0] exp_wd);
    int cyc;
    int done_cyc;
    int wr_cyc;
    logic [LRU_W-1:0] wd;
    @(negedge clk);
    check({tag, " idle ready"}, 32'(touch_ready), 32'd1);
    lru_rdata   = word;
    touch_way   = way;
    touch_valid = 1'b1;
    cyc = 0; done_cyc = -1; wr_cyc = -1; wd = {LRU_W{1'b0}};
    while (done_cyc < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        touch_valid = 1'b0;
        check({tag, " busy"}, 32'({touch_ready, victim_valid}), 32'd0);
      end
      if (lru_write) begin
        wr_cyc = cyc;
        wd     = lru_wdata;
      end
      if (touch_done) done_cyc = cyc;
    end
    check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, " write cycle"}, 32'(wr_cyc), exp_wr ? 32'(exp_done) : 32'hFFFF_FFFF);
    if (exp_wr) check({tag, " wdata"}, 32'(wd), 32'(exp_wd));
    @(posedge clk); #1;
    check({tag, " ready back"}, 32'(touch_ready), 32'd1);
  endtask

  typedef struct {
    logic [LRU_W-1:0] word;
    logic [IDX_W-1:0] way;
    int               done_s;
    logic             wr;
    logic [LRU_W-1:0] wd;
    logic [IDX_W-1:0] vict;
  } vec_t;

  vec_t vt[5];

  initial begin
    int               p;
    int               j;
    int               cyc;
    int               n_wr;
    int               exp_d;
    logic             pend;
    logic             seen;
    logic             merr;
    logic [IDX_W-1:0] t;
    logic [IDX_W-1:0] f[WAYS];
    logic [LRU_W-1:0] w;
    logic [LRU_W-1:0] nw;
    logic [IDX_W-1:0] way;
    int               wcyc[2];
    logic [LRU_W-1:0] wdat[2];

    vt[0] = '{24'hFAC688, 3'd0, 9, 1'b1, 24'h1F58D1, 3'd0};
    vt[1] = '{24'hFAC688, 3'd7, 2, 1'b0, 24'h000000, 3'd0};
    vt[2] = '{24'hFAC688, 3'd3, 6, 1'b1, 24'h7F5888, 3'd0};
    vt[3] = '{24'h053977, 3'd0, 2, 1'b0, 24'h000000, 3'd7};
    vt[4] = '{24'h053977, 3'd4, 6, 1'b1, 24'h80A777, 3'd7};

    reset = 1'b1; touch_valid = 1'b0; touch_way = 3'd0; lru_rdata = 24'h000000;
    #12;
    check("rst ready",  32'(touch_ready),  32'd1);
    check("rst done",   32'(touch_done),   32'd0);
    check("rst write",  32'(lru_write),    32'd0);
    check("rst wdata",  32'(lru_wdata),    32'd0);
    check("rst err",    32'(lru_err),      32'd0);
    check("rst vvalid", 32'(victim_valid), 32'd1);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lru_rdata = vt[i].word;
      #1;
      check("victim way", 32'(victim_way), 32'(vt[i].vict));
`ifdef VC_LRU_FAST_EN
      exp_d = 1;
`else
      exp_d = vt[i].done_s;
`endif
      run_touch("vec", vt[i].word, vt[i].way, exp_d, vt[i].wr, vt[i].wd);
    end
    check("err clean", 32'(lru_err), 32'd0);

    run_touch("miss", 24'h000000, 3'd5, lat(-1), 1'b0, 24'h000000);
    check("miss err", 32'(lru_err), 32'd1);
    model(24'hFAC688, 3'd2, p, nw);
    run_touch("after miss", 24'hFAC688, 3'd2, lat(p), 1'b1, nw);
    check("err sticky", 32'(lru_err), 32'd1);

    // Reset mid-operation must abort without a write and clear the error flag.
    @(negedge clk);
    lru_rdata = 24'hFAC688; touch_way = 3'd0; touch_valid = 1'b1;
    @(posedge clk); #1 touch_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("mid rst ready", 32'(touch_ready), 32'd1);
    check("mid rst write", 32'(lru_write),   32'd0);
    check("mid rst done",  32'(touch_done),  32'd0);
    check("mid rst err",   32'(lru_err),     32'd0);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (lru_write || touch_done) seen = 1'b1;
    end
    check("post rst quiet", 32'(seen), 32'd0);

    // Back-to-back requests with valid held high.
    @(negedge clk);
    lru_rdata = 24'hFAC688; touch_way = 3'd0; touch_valid = 1'b1;
    cyc = 0; n_wr = 0; pend = 1'b0;
    wcyc[0] = -1; wcyc[1] = -1; wdat[0] = 24'h0; wdat[1] = 24'h0;
    while (cyc < 60 && n_wr < 2) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) touch_way = 3'd1;
      if (pend) begin
        touch_valid = 1'b0;
        pend = 1'b0;
      end
      if (lru_write) begin
        wcyc[n_wr] = cyc;
        wdat[n_wr] = lru_wdata;
        n_wr++;
      end
      if (touch_ready && touch_valid && cyc >= 1) pend = 1'b1;
    end
    touch_valid = 1'b0;
    check("b2b write0 cyc",  32'(wcyc[0]), 32'(lat(0)));
    check("b2b write0 data", 32'(wdat[0]), 32'h1F58D1);
    check("b2b write1 cyc",  32'(wcyc[1]), 32'(lat(0) + 1 + lat(1)));
    check("b2b write1 data", 32'(wdat[1]), 32'h3F58D0);
    @(posedge clk); #1;

    merr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < WAYS; i++) f[i] = IDX_W'(i);
      for (int i = WAYS-1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = f[i]; f[i] = f[j]; f[j] = t;
      end
      for (int i = 0; i < WAYS; i++) w[i*IDX_W +: IDX_W] = f[i];
      if ($urandom_range(4, 0) == 0) w = 24'($urandom);
      way = 3'($urandom_range(7, 0));
      model(w, way, p, nw);
      if (p < 0) merr = 1'b1;
      run_touch("rand", w, way, lat(p), (p >= 0 && p < WAYS-1), nw);
      check("rand err", 32'(lru_err), 32'(merr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
